conv_mac: RTL and testbench
===========================

# conv_mac

Multiply-accumulate stage directly downstream of the 2-D convolution window generator. It consumes the zero-padded 9-tap pixel stream (one 3x3 window per output pixel, column-major within the window) and multiplies each tap by a programmable signed kernel coefficient. It rounds, shifts and saturates each window sum, then emits one output pixel per window with its write address and a write strobe for the result memory.

## Interface
- DataBitWidth, 12, pixel width (unsigned) in and out
- CoefBitWidth, 8, kernel coefficient width (two's complement)
- AddressBitWidth, 17, write address width
- ShiftAmount, 4, right shift applied to the window sum (0..15)
- NumPixels, 25, output pixels per frame (NoOfRows*NoOfColumns)
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- start  in  1  frame start (IDLE) / acknowledge (DONE)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  tap index 0..8; indices 9..15 are ignored
- coef_in  in  CoefBitWidth  coefficient value
- in_valid  in  1  d_in carries a valid tap this cycle
- d_in  in  DataBitWidth  tap pixel (already 0 for padded positions)
- d_out  out  DataBitWidth  result pixel
- WriteAddress  out  AddressBitWidth  address of d_out
- wr_en  out  1  one-cycle write strobe for d_out/WriteAddress
- ready  out  1  frame complete

## Operation
- Tap index k = 3*c + r, where r and c are the window row and column (0..2). This matches the upstream order: the row varies fastest.
- States: IDLE=0, RUN=1, DONE=2.
  - IDLE: coefficient writes are accepted. start -> RUN; tap counter, accumulator and output counter clear to 0.
  - RUN: each in_valid cycle performs acc += sext(d_in) * coef[tap] and increments tap.
  - DONE: ready=1. start -> IDLE with ready cleared.
- Tap 8 handling (tap 8 valid): tap=0, acc=0, and sum = acc + product.
- Result = sat((sum + 2^(ShiftAmount-1)) >>> ShiftAmount) when ShiftAmount>0, otherwise sum.
- Saturation clamps to 0..2^DataBitWidth-1.
- Accumulator: signed, DataBitWidth+CoefBitWidth+5 bits (25 by default). Overflow is impossible for 9 taps.
- On the emitted output, WriteAddress = output counter, then the counter increments.
- After NumPixels outputs have been emitted -> DONE.
- coef_we outside IDLE: ignored, and the coefficients are unchanged. Coefficients survive DONE->IDLE and are reset to 0 only by rst.
- in_valid in IDLE or DONE: ignored.

## Timing
- Reset values: d_out=0, WriteAddress=0, wr_en=0, ready=0, state=IDLE, all coefficients 0.
- in_valid gaps are allowed anywhere within a window; the tap counter holds through them.
- Latency: tap 8 sampled at edge t -> wr_en=1 with valid d_out/WriteAddress during the cycle after t, for exactly one cycle.
- Back-to-back windows: the tap 0 of the next window may arrive in the cycle right after tap 8.
- DONE entry: same edge that raises wr_en for the last pixel. ready rises at that edge, and wr_en, d_out and WriteAddress remain valid for that cycle.
- start in RUN: ignored.
- rst mid-frame: next cycle all outputs are at their reset values and coefficients are cleared. A partial window is discarded.
- d_out and WriteAddress hold their last value between strobes.

## Structure
- Shared package conv_pkg holds:
  - NoOfRows and NoOfColumns (5/5), shared with the window generator
  - FilterSize=3 and the tap count 9
  - the state encodings IDLE/RUN/DONE
- Sub-module conv_coef_bank holds the 9-entry coefficient register file: write port (coef_we/coef_addr/coef_in, gated by IDLE) and a combinational read by tap index.
- MAC datapath, counters and FSM live in conv_mac.

## Test plan
- Identity kernel: coef[4]=16, others 0, ShiftAmount=4, ramp image p(i)=i*10 streamed as 25 windows -> 25 strobes, d_out(i)=10*i, WriteAddress 0..24, ready after the 25th strobe.
- Box kernel: all coefs 1, ShiftAmount=0, constant image 100 with zero padding -> corners 400, edges 600, centre pixels 900.
- Saturation: all coefs 127 and all taps 4095 -> 4095; all coefs -1 and nonzero taps -> 0. Rounding check: sum 24 with shift 4 -> 2.
- Random 1-in-3 in_valid gaps with the box kernel -> same outputs as the gap-free run; wr_en exactly one cycle after each tap 8.
- coef_we during RUN (coef[4]=99) -> outputs unchanged. After DONE, start then a rewrite in IDLE -> new value used in the next frame.
- rst asserted after 4 taps of window 7 -> all outputs reset next cycle. A fresh frame with reloaded coefs gives the correct results from WriteAddress 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution pipeline
// (window generator and MAC stage).
package conv_pkg;

  localparam int NoOfRows    = 5;
  localparam int NoOfColumns = 5;
  localparam int FilterSize  = 3;
  localparam int NumTaps     = FilterSize * FilterSize;
  localparam int TapIdxW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_coef_bank.sv
// Nine-entry signed kernel coefficient register file with a gated write
// port and a combinational read by tap index.
module conv_coef_bank
  import conv_pkg::*;
#(
  parameter int CoefBitWidth = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_allow,
  input  logic                    coef_we,
  input  logic [TapIdxW-1:0]      coef_addr,
  input  logic [CoefBitWidth-1:0] coef_in,
  input  logic [TapIdxW-1:0]      rd_idx,
  output logic [CoefBitWidth-1:0] coef_rd
);

  logic [CoefBitWidth-1:0] coef_mem [NumTaps];

  // Addresses past the last tap fall through without touching any entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumTaps; i++) coef_mem[i] <= '0;
    end else if (wr_allow && coef_we && (coef_addr < TapIdxW'(NumTaps))) begin
      coef_mem[coef_addr] <= coef_in;
    end
  end

  assign coef_rd = (rd_idx < TapIdxW'(NumTaps)) ? coef_mem[rd_idx] : '0;

endmodule

// File: rtl/conv_mac.sv
// Per-window multiply-accumulate with round, shift and saturate; emits one
// result pixel with its write address per 3x3 window.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DataBitWidth    = 12,
  parameter int CoefBitWidth    = 8,
  parameter int AddressBitWidth = 17,
  parameter int ShiftAmount     = 4,
  parameter int NumPixels       = NoOfRows * NoOfColumns
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       coef_we,
  input  logic [TapIdxW-1:0]         coef_addr,
  input  logic [CoefBitWidth-1:0]    coef_in,
  input  logic                       in_valid,
  input  logic [DataBitWidth-1:0]    d_in,
  output logic [DataBitWidth-1:0]    d_out,
  output logic [AddressBitWidth-1:0] WriteAddress,
  output logic                       wr_en,
  output logic                       ready,
  output conv_state_e                state_dbg
);

  localparam int AccW = DataBitWidth + CoefBitWidth + 5;
  localparam logic [TapIdxW-1:0] LastTap = TapIdxW'(NumTaps - 1);
  localparam logic [AddressBitWidth-1:0] LastPix = AddressBitWidth'(NumPixels - 1);
  localparam logic signed [AccW-1:0] RoundBias = AccW'((1 << ShiftAmount) >> 1);
  localparam logic signed [AccW-1:0] MaxPix = AccW'((1 << DataBitWidth) - 1);

  conv_state_e                state;
  logic [TapIdxW-1:0]         tap;
  logic signed [AccW-1:0]     acc;
  logic [AddressBitWidth-1:0] out_cnt;
  logic [CoefBitWidth-1:0]    coef_cur;

  logic signed [AccW-1:0]     pix_x;
  logic signed [AccW-1:0]     coef_x;
  logic signed [AccW-1:0]     product;
  logic signed [AccW-1:0]     sum;
  logic signed [AccW-1:0]     shifted;
  logic [DataBitWidth-1:0]    result;

  conv_coef_bank #(
    .CoefBitWidth (CoefBitWidth)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_allow  (state == IDLE),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_in   (coef_in),
    .rd_idx    (tap),
    .coef_rd   (coef_cur)
  );

  // Pixels are unsigned, so they enter the signed product with a zero top bit.
  assign pix_x   = {{(AccW - DataBitWidth){1'b0}}, d_in};
  assign coef_x  = {{(AccW - CoefBitWidth){coef_cur[CoefBitWidth-1]}}, coef_cur};
  assign product = pix_x * coef_x;
  assign sum     = acc + product;
  assign shifted = (sum + RoundBias) >>> ShiftAmount;

  always_comb begin
    result = shifted[DataBitWidth-1:0];
    if (shifted[AccW-1]) result = '0;
    else if (shifted > MaxPix) result = '1;
  end

  // Input side has no backpressure: a tap is consumed on every clk edge where
  // in_valid is high in RUN; wr_en is a single-cycle strobe with no ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tap          <= '0;
      acc          <= '0;
      out_cnt      <= '0;
      d_out        <= '0;
      WriteAddress <= '0;
      wr_en        <= 1'b0;
      ready        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            tap     <= '0;
            acc     <= '0;
            out_cnt <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (tap == LastTap) begin
              tap          <= '0;
              acc          <= '0;
              d_out        <= result;
              WriteAddress <= out_cnt;
              wr_en        <= 1'b1;
              out_cnt      <= out_cnt + 1'b1;
              if (out_cnt == LastPix) begin
                state <= DONE;
                ready <= 1'b1;
              end
            end else begin
              tap <= tap + 1'b1;
              acc <= sum;
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_conv_mac.sv
// Bench for conv_mac: two instances (shift 4 and shift 0) share stimulus and
// are checked against a direct 2-D convolution reference model.
module tb_conv_mac;
  import conv_pkg::*;

  localparam int DW = 12;
  localparam int CW = 8;
  localparam int AW = 17;
  localparam int NP = NoOfRows * NoOfColumns;
  localparam int W  = AW + DW;

  typedef struct {
    int case_id;
    int pix;
    int exp4;
    int exp0;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [CW-1:0] coef_in;
  logic          in_valid;
  logic [DW-1:0] d_in;

  logic [DW-1:0] d_out4, d_out0;
  logic [AW-1:0] wa4, wa0;
  logic          wr_en4, wr_en0, ready4, ready0;
  conv_state_e   st4, st0;

  int n_checks = 0;
  int n_errors = 0;
  int kern [9];
  int img [NP];
  int cap4 [NP];
  int cap0 [NP];
  logic [W-1:0] exp_q4 [$];
  logic [W-1:0] exp_q0 [$];
  vec_t vecs [$];
  logic drv_tap8 = 1'b0;
  logic exp_strobe = 1'b0;
  logic mon_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv_mac #(.ShiftAmount(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_in(coef_in), .in_valid(in_valid), .d_in(d_in), .d_out(d_out4),
    .WriteAddress(wa4), .wr_en(wr_en4), .ready(ready4), .state_dbg(st4)
  );

  conv_mac #(.ShiftAmount(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_in(coef_in), .in_valid(in_valid), .d_in(d_in), .d_out(d_out0),
    .WriteAddress(wa0), .wr_en(wr_en0), .ready(ready0), .state_dbg(st0)
  );

  // ---------------- reference model ----------------
  function automatic int floor_div(input int a, input int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int ref_pix(input int p, input int sh);
    int row = p / NoOfColumns;
    int col = p % NoOfColumns;
    int sum = 0;
    int res;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = row + dr;
        int cc = col + dc;
        if (rr >= 0 && rr < NoOfRows && cc >= 0 && cc < NoOfColumns)
          sum += img[rr * NoOfColumns + cc] * kern[3 * (dc + 1) + (dr + 1)];
      end
    end
    res = (sh > 0) ? floor_div(sum + (2 ** (sh - 1)), 2 ** sh) : sum;
    if (res < 0) res = 0;
    if (res > 4095) res = 4095;
    return res;
  endfunction

  function automatic vec_t mk(input int c, input int p, input int e4, input int e0);
    vec_t v;
    v.case_id = c; v.pix = p; v.exp4 = e4; v.exp0 = e0;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) exp_strobe <= !rst && in_valid && drv_tap8;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      check("wr_en4_timing", wr_en4, exp_strobe);
      check("wr_en0_timing", wr_en0, exp_strobe);
      if (wr_en4) begin
        if (exp_q4.size() == 0) check("extra_strobe4", 1, 0);
        else begin
          e = exp_q4.pop_front();
          check("d_out4", d_out4, e[DW-1:0]);
          check("addr4", wa4, e[W-1:DW]);
        end
        if (wa4 < AW'(NP)) cap4[wa4] = int'(d_out4);
      end
      if (wr_en0) begin
        if (exp_q0.size() == 0) check("extra_strobe0", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check("d_out0", d_out0, e[DW-1:0]);
          check("addr0", wa0, e[W-1:DW]);
        end
        if (wa0 < AW'(NP)) cap0[wa0] = int'(d_out0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_tap(input int v, input logic is8);
    in_valid = 1'b1;
    d_in     = DW'(v);
    drv_tap8 = is8;
    cycle();
    in_valid = 1'b0;
    drv_tap8 = 1'b0;
  endtask

  task automatic load_kern();
    coef_we = 1'b1;
    for (int k = 0; k < 9; k++) begin
      coef_addr = 4'(k);
      coef_in   = CW'(kern[k]);
      cycle();
    end
    coef_addr = 4'd12;
    coef_in   = 8'd55;
    cycle();
    coef_we = 1'b0;
  endtask

  task automatic push_expected();
    for (int p = 0; p < NP; p++) begin
      exp_q4.push_back({AW'(p), DW'(ref_pix(p, 4))});
      exp_q0.push_back({AW'(p), DW'(ref_pix(p, 0))});
      cap4[p] = -1;
      cap0[p] = -1;
    end
  endtask

  // Streams one window column by column, row fastest; limit truncates it.
  task automatic stream_window(input int p, input bit gaps, input int limit);
    int row = p / NoOfColumns;
    int col = p % NoOfColumns;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        int k = 3 * c + r;
        int rr = row + r - 1;
        int cc = col + c - 1;
        int v = 0;
        if (k < limit) begin
          if (gaps && $urandom_range(2) == 0) cycle();
          if (rr >= 0 && rr < NoOfRows && cc >= 0 && cc < NoOfColumns) v = img[rr * NoOfColumns + cc];
          send_tap(v, k == 8);
        end
      end
    end
  endtask

  task automatic run_frame(input bit gaps, input bit poke);
    int n = 0;
    push_expected();
    pulse_start();
    check("state_run", st4, RUN);
    for (int p = 0; p < NP; p++) begin
      if (poke && p == 3) begin
        coef_we = 1'b1; coef_addr = 4'd4; coef_in = 8'd99; start = 1'b1;
        cycle();
        coef_we = 1'b0; start = 1'b0;
      end
      stream_window(p, gaps, 9);
    end
    while (!(ready4 && ready0) && n < 20) begin
      cycle();
      n++;
    end
    check("ready_latency", n, 0);
    cycle();
    check("queue4_drained", exp_q4.size(), 0);
    check("queue0_drained", exp_q0.size(), 0);
    check("state_done", st0, DONE);
    check("ready_held", ready4, 1);
    // Writes and taps while DONE must leave no trace.
    coef_we = 1'b1; coef_addr = 4'd4; coef_in = 8'd77;
    cycle();
    coef_we = 1'b0;
    for (int i = 0; i < 9; i++) send_tap($urandom_range(4095), 1'b0);
    pulse_start();
    check("ready4_cleared", ready4, 0);
    check("ready0_cleared", ready0, 0);
    check("state_idle", st4, IDLE);
  endtask

  task automatic setup_case(input int id);
    for (int k = 0; k < 9; k++) kern[k] = 0;
    for (int p = 0; p < NP; p++) begin
      case (id)
        0: img[p] = 10 * p;
        1, 5: img[p] = 100;
        2: img[p] = 4095;
        3: img[p] = 50;
        default: img[p] = 1;
      endcase
    end
    case (id)
      0: kern[4] = 16;
      1, 5: for (int k = 0; k < 9; k++) kern[k] = 1;
      2: for (int k = 0; k < 9; k++) kern[k] = 127;
      3: for (int k = 0; k < 9; k++) kern[k] = -1;
      default: kern[4] = 24;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_out4"}, d_out4, 0);
    check({tag, "_addr4"}, wa4, 0);
    check({tag, "_wr_en4"}, wr_en4, 0);
    check({tag, "_ready4"}, ready4, 0);
    check({tag, "_state4"}, st4, IDLE);
    check({tag, "_d_out0"}, d_out0, 0);
    check({tag, "_addr0"}, wa0, 0);
    check({tag, "_ready0"}, ready0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_in = '0;
    in_valid = 1'b0; d_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");
    mon_en = 1'b1;

    vecs.push_back(mk(0, 0, 0, 0));
    vecs.push_back(mk(0, 7, 70, 1120));
    vecs.push_back(mk(0, 12, 120, 1920));
    vecs.push_back(mk(0, 24, 240, 3840));
    vecs.push_back(mk(1, 0, 25, 400));
    vecs.push_back(mk(1, 2, 38, 600));
    vecs.push_back(mk(1, 10, 38, 600));
    vecs.push_back(mk(1, 12, 56, 900));
    vecs.push_back(mk(1, 24, 25, 400));
    vecs.push_back(mk(2, 0, 4095, 4095));
    vecs.push_back(mk(2, 12, 4095, 4095));
    vecs.push_back(mk(3, 0, 0, 0));
    vecs.push_back(mk(3, 12, 0, 0));
    vecs.push_back(mk(4, 0, 2, 24));
    vecs.push_back(mk(4, 6, 2, 24));
    vecs.push_back(mk(5, 0, 25, 400));
    vecs.push_back(mk(5, 12, 56, 900));
    vecs.push_back(mk(5, 22, 38, 600));

    for (int id = 0; id < 6; id++) begin
      setup_case(id);
      load_kern();
      run_frame(id == 5, 1'b0);
      foreach (vecs[i]) begin
        if (vecs[i].case_id == id) begin
          check($sformatf("vec%0d_p%0d_s4", id, vecs[i].pix), cap4[vecs[i].pix], vecs[i].exp4);
          check($sformatf("vec%0d_p%0d_s0", id, vecs[i].pix), cap0[vecs[i].pix], vecs[i].exp0);
        end
      end
    end

    // coef write and start during RUN are ignored; an IDLE rewrite takes effect
    setup_case(0);
    load_kern();
    run_frame(1'b0, 1'b1);
    check("poke_ignored", cap4[12], 120);
    kern[4] = 32;
    coef_we = 1'b1; coef_addr = 4'd4; coef_in = 8'd32;
    cycle();
    coef_we = 1'b0;
    run_frame(1'b0, 1'b0);
    check("rewrite_used", cap4[12], 240);

    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 9; k++) kern[k] = int'($urandom_range(255)) - 128;
      for (int p = 0; p < NP; p++) img[p] = int'($urandom_range(4095));
      load_kern();
      run_frame(1'b1, 1'b0);
    end

    // reset in the middle of window 7
    setup_case(0);
    load_kern();
    push_expected();
    pulse_start();
    for (int p = 0; p < 7; p++) stream_window(p, 1'b0, 9);
    stream_window(7, 1'b0, 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_outputs("midrst");
    check("strobes_before_rst", exp_q4.size(), NP - 7);
    exp_q4.delete();
    exp_q0.delete();
    for (int k = 0; k < 9; k++) kern[k] = 0;
    run_frame(1'b0, 1'b0);
    check("coefs_cleared", cap0[12], 0);
    setup_case(0);
    load_kern();
    run_frame(1'b0, 1'b0);
    check("after_rst_first", cap4[0], 0);
    check("after_rst_last", cap4[24], 240);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
